// File: rtl/serial_in.sv
// UART receiver: 8N1, LSB first, DDS-generated 16x sample tick, 3-sample majority
// vote per bit, writes each good byte into a downstream FIFO with one-clock pulses.
module serial_in #(
    parameter int unsigned CLOCK      = 56842105,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_serial_rx,
    input  logic       i_fifo_full,
    output logic [7:0] o_data,
    output logic       o_fifo_write_req,
    output logic       o_frame_error,
    output logic       o_overrun,
    output logic       o_busy
);
    localparam logic [63:0] INC64 = ((64'd1 << 32) * 64'(BAUD_RATE) * 64'(OVERSAMPLE)) / 64'(CLOCK);
    localparam logic [31:0] INC   = INC64[31:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [1:0]  sync_q;
    logic [1:0]  valid_q;
    logic        armed_q;
    logic        rx_prev_q;
    logic [31:0] acc_q;
    logic [3:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shreg_q;
    logic [1:0]  samp_q;

    logic [32:0] acc_d;
    logic        tick;
    logic        rx_s;
    logic        maj;

    assign rx_s  = sync_q[1];
    assign acc_d = {1'b0, acc_q} + {1'b0, INC};
    assign tick  = acc_d[32];
    assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign o_busy = (state_q != IDLE);

    // armed_q blocks a start until the real line has been seen high after reset,
    // so a line held low across reset release cannot fake a falling edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q          <= IDLE;
            sync_q           <= 2'b11;
            valid_q          <= 2'b00;
            armed_q          <= 1'b0;
            rx_prev_q        <= 1'b1;
            acc_q            <= '0;
            cnt_q            <= '0;
            idx_q            <= '0;
            shreg_q          <= '0;
            samp_q           <= '0;
            o_data           <= 8'h00;
            o_fifo_write_req <= 1'b0;
            o_frame_error    <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            sync_q           <= {sync_q[0], i_serial_rx};
            valid_q          <= {valid_q[0], 1'b1};
            armed_q          <= armed_q | (valid_q[1] & rx_s);
            rx_prev_q        <= rx_s;
            acc_q            <= acc_d[31:0];
            o_fifo_write_req <= 1'b0;
            o_frame_error    <= 1'b0;
            o_overrun        <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (armed_q && rx_prev_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                default: begin
                    if (tick) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) samp_q[0] <= rx_s;
                        if (cnt_q == 4'd8) samp_q[1] <= rx_s;
                        if (cnt_q == 4'd9) begin
                            case (state_q)
                                START: if (maj) state_q <= IDLE;
                                DATA:  shreg_q <= {maj, shreg_q[7:1]};
                                STOP: begin
                                    // leave at mid-stop so the next start edge is caught
                                    state_q <= IDLE;
                                    if (!maj) begin
                                        o_frame_error <= 1'b1;
                                    end else if (i_fifo_full) begin
                                        o_overrun <= 1'b1;
                                    end else begin
                                        o_data           <= shreg_q;
                                        o_fifo_write_req <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        if (cnt_q == 4'd15) begin
                            case (state_q)
                                START: state_q <= DATA;
                                DATA: begin
                                    if (idx_q == 3'd7) state_q <= STOP;
                                    else               idx_q   <= idx_q + 3'd1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_in.sv
// Bench for serial_in: drives UART frames in real time at default parameters and
// compares observed FIFO writes / error pulses against a frame-level model.
`timescale 1ns/1ps
module tb_serial_in;
    localparam real BIT_NS = 1.0e9 / 115200.0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       full = 1'b0;
    logic [7:0] o_data;
    logic       wr, fe, ov, busy;

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_fe = 0, n_ov = 0;
    logic [7:0] got_q[$];

    serial_in dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_serial_rx(rx), .i_fifo_full(full),
        .o_data(o_data), .o_fifo_write_req(wr), .o_frame_error(fe),
        .o_overrun(ov), .o_busy(busy)
    );

    always #8.796 clk = ~clk;

    // counts high cycles, so a pulse wider than one clock shows up as an extra event
    always @(negedge clk) begin
        if (wr) begin n_wr++; got_q.push_back(o_data); end
        if (fe) n_fe++;
        if (ov) n_ov++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout sim time exceeded bound");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns, input logic after);
        rx = 1'b0; #(bit_ns);
        for (int i = 0; i < 8; i++) begin rx = b[i]; #(bit_ns); end
        rx = stop; #(bit_ns);
        rx = after;
    endtask

    task automatic idle(input real nbits);
        rx = 1'b1; #(nbits * BIT_NS);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_data, wr, fe, ov, busy} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got %h exp 000", {o_data, wr, fe, ov, busy});
        end
        rst_n = 1'b1;
        idle(1.0);
        checks++;
        if (busy !== 1'b0 || n_wr + n_fe + n_ov != 0) begin
            errors++; $display("FAIL reset_idle busy %b pulses %0d exp 0/0", busy, n_wr + n_fe + n_ov);
        end
    endtask

    task automatic test_basic;
        int w0 = n_wr, f0 = n_fe, v0 = n_ov;
        logic mid_busy = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, BIT_NS, 1'b1);
            begin #(1.5 * BIT_NS); @(negedge clk); mid_busy = busy; end
        join
        idle(1.5);
        checks++;
        if (mid_busy !== 1'b1) begin errors++; $display("FAIL a5_busy_mid got %b exp 1", mid_busy); end
        checks++;
        if (n_wr - w0 != 1) begin errors++; $display("FAIL a5_writes got %0d exp 1", n_wr - w0); end
        checks++;
        if (n_fe - f0 + n_ov - v0 != 0) begin errors++; $display("FAIL a5_err_pulses got %0d exp 0", n_fe - f0 + n_ov - v0); end
        checks++;
        if (o_data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", o_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_glitch;
        int t0 = n_wr + n_fe + n_ov;
        rx = 1'b0; #2000; rx = 1'b1;
        idle(1.5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
        checks++;
        if (n_wr + n_fe + n_ov - t0 != 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", n_wr + n_fe + n_ov - t0); end
        checks++;
        if (o_data !== 8'hA5) begin errors++; $display("FAIL glitch_data got %h exp a5", o_data); end
    endtask

    task automatic test_frame_error_break;
        int w0 = n_wr, f0 = n_fe, v0 = n_ov;
        send_frame(8'h00, 1'b0, BIT_NS, 1'b0);
        #(2.0 * BIT_NS);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", busy); end
        idle(1.5);
        checks++;
        if (n_fe - f0 != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", n_fe - f0); end
        checks++;
        if (n_wr - w0 + n_ov - v0 != 0) begin errors++; $display("FAIL ferr_other got %0d exp 0", n_wr - w0 + n_ov - v0); end
        checks++;
        if (o_data !== 8'hA5) begin errors++; $display("FAIL ferr_data got %h exp a5", o_data); end
    endtask

    task automatic test_overrun;
        int w0 = n_wr, f0 = n_fe, v0 = n_ov;
        full = 1'b0;
        send_frame(8'h11, 1'b1, BIT_NS, 1'b1);
        idle(1.0);
        full = 1'b1;
        send_frame(8'h3C, 1'b1, BIT_NS, 1'b1);
        idle(1.0);
        full = 1'b0;
        checks++;
        if (n_wr - w0 != 1) begin errors++; $display("FAIL ovr_writes got %0d exp 1", n_wr - w0); end
        checks++;
        if (n_ov - v0 != 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", n_ov - v0); end
        checks++;
        if (n_fe - f0 != 0) begin errors++; $display("FAIL ovr_ferr got %0d exp 0", n_fe - f0); end
        checks++;
        if (o_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %h exp 11", o_data); end
    endtask

    task automatic test_back_to_back;
        int w0 = n_wr, f0 = n_fe;
        send_frame(8'h55, 1'b1, BIT_NS / 1.03, 1'b1);
        send_frame(8'hAA, 1'b1, BIT_NS / 0.97, 1'b1);
        idle(1.5);
        checks++;
        if (n_wr - w0 != 2) begin errors++; $display("FAIL b2b_writes got %0d exp 2", n_wr - w0); end
        else begin
            checks++;
            if (got_q[got_q.size()-2] !== 8'h55 || got_q[got_q.size()-1] !== 8'hAA) begin
                errors++; $display("FAIL b2b_bytes got %h %h exp 55 aa", got_q[got_q.size()-2], got_q[got_q.size()-1]);
            end
        end
        checks++;
        if (n_fe - f0 != 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", n_fe - f0); end
    endtask

    task automatic test_reset_midframe;
        int t0 = n_wr + n_fe + n_ov;
        int w0 = n_wr;
        logic [11:0] in_rst = '1;
        fork
            send_frame(8'hF0, 1'b1, BIT_NS, 1'b1);
            begin
                #(5.5 * BIT_NS);
                rst_n = 1'b0;
                repeat (5) @(negedge clk);
                in_rst = {o_data, wr, fe, ov, busy};
                #200;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(1.0);
        checks++;
        if (in_rst !== 12'h000) begin errors++; $display("FAIL midrst_outputs got %h exp 000", in_rst); end
        checks++;
        if (n_wr + n_fe + n_ov - t0 != 0) begin errors++; $display("FAIL midrst_pulses got %0d exp 0", n_wr + n_fe + n_ov - t0); end
        send_frame(8'h81, 1'b1, BIT_NS, 1'b1);
        idle(1.5);
        checks++;
        if (n_wr - w0 != 1 || o_data !== 8'h81) begin
            errors++; $display("FAIL midrst_81 writes %0d data %h exp 1 81", n_wr - w0, o_data);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_data = o_data;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b = 8'($urandom);
            logic fl = ($urandom_range(0, 3) == 0);
            logic st = ($urandom_range(0, 4) != 0);
            int err = $urandom_range(0, 40) - 20;
            int w0 = n_wr, f0 = n_fe, v0 = n_ov;
            int ew, ef, ev;
            ew = (st && !fl) ? 1 : 0;
            ef = st ? 0 : 1;
            ev = (st && fl) ? 1 : 0;
            if (ew == 1) exp_data = b;
            full = fl;
            send_frame(b, st, BIT_NS * (1.0 + real'(err) / 1000.0), 1'b1);
            idle(1.0);
            full = 1'b0;
            checks++;
            if (n_wr - w0 != ew || n_fe - f0 != ef || n_ov - v0 != ev) begin
                errors++; $display("FAIL rnd%0d_pulses got w%0d f%0d o%0d exp w%0d f%0d o%0d", k,
                                   n_wr - w0, n_fe - f0, n_ov - v0, ew, ef, ev);
            end
            checks++;
            if (o_data !== exp_data) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", k, o_data, exp_data); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error_break;
        test_overrun;
        test_back_to_back;
        test_reset_midframe;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
